// File: rtl/sfp_poll_pkg.sv
// rtl/sfp_poll_pkg.sv - shared state encoding and readback RAM address packing for the SFP poll scheduler
package sfp_poll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RUN    = 2'd2,
    DWELL  = 2'd3
  } poll_state_e;

  // {cage, slot} packing; callers size-cast the result to their own address width
  function automatic logic [31:0] ram_addr(input logic [31:0] cage, input logic [31:0] slot,
                                           input int aw);
    return (cage << aw) | slot;
  endfunction

endpackage

// File: rtl/sfp_poll_ram.sv
// rtl/sfp_poll_ram.sv - simple dual-port result RAM, one write port, registered read-before-write read port
module sfp_poll_ram #(
  parameter int ADDR_W = 6,
  parameter int DW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data
);

  logic [DW-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sfp_poll_sched.sv
// rtl/sfp_poll_sched.sv - round-robin scheduler sharing one sfp_ddmi polling engine across SFP cages
module sfp_poll_sched
  import sfp_poll_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int PW     = 2,
  parameter int AW     = 4,
  parameter int SETTLE = 8,
  parameter int TMO_W  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [NPORT-1:0] port_mask,
  input  logic [15:0]      dwell,
  output logic [PW-1:0]    eng_sel,
  output logic             eng_run,
  input  logic             eng_strobe,
  input  logic [7:0]       eng_pc,
  input  logic [8:0]       eng_result,
  input  logic             eng_done,
  input  logic [PW+AW-1:0] rd_addr,
  output logic [8:0]       rd_data,
  output logic [NPORT-1:0] fresh,
  input  logic [NPORT-1:0] fresh_clr,
  output logic [NPORT-1:0] tmo_err,
  output logic [15:0]      sweep_cnt,
  output logic             busy
);

  localparam int SW = $clog2(SETTLE + 1);

  poll_state_e      state, state_nxt;
  logic [PW-1:0]    sel_nxt;
  logic [SW-1:0]    settle_cnt;
  logic [TMO_W-1:0] wdog;
  logic [15:0]      dwell_cnt;
  logic             done_set, tmo_set, wrap_inc;
  logic             dwell_last, ram_we;
  logic [PW:0]      first_pick, next_pick;
  logic [NPORT-1:0] done_vec, tmo_vec;
  logic [PW+AW-1:0] wr_addr;

  // Returns {found, index} of the first set mask bit strictly after cur, wrapping through cur itself
  function automatic logic [PW:0] next_cage(input logic [NPORT-1:0] mask, input logic [PW-1:0] cur);
    logic [PW:0] pick;
    int          j;
    pick = '0;
    for (int i = 1; i <= NPORT; i++) begin
      j = (int'(cur) + i) % NPORT;
      if (mask[j] && !pick[PW]) pick = {1'b1, PW'(j)};
    end
    return pick;
  endfunction

  assign first_pick = next_cage(port_mask, PW'(NPORT - 1));
  assign next_pick  = next_cage(port_mask, eng_sel);
  assign dwell_last = ({1'b0, dwell_cnt} + 17'd1) >= {1'b0, dwell};

  assign eng_run = (state == RUN);
  assign busy    = (state != IDLE);

  assign ram_we  = (state == RUN) && eng_strobe && (32'(eng_pc) < (32'd1 << AW));
  assign wr_addr = (PW+AW)'(ram_addr(32'(eng_sel), 32'(eng_pc[AW-1:0]), AW));

  always_comb begin
    state_nxt = state;
    sel_nxt   = eng_sel;
    done_set  = 1'b0;
    tmo_set   = 1'b0;
    wrap_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && first_pick[PW]) begin
          state_nxt = SELECT;
          sel_nxt   = first_pick[PW-1:0];
        end
      end
      SELECT: begin
        if (!enable) state_nxt = IDLE;
        else if (settle_cnt == SW'(SETTLE - 1)) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (eng_done) begin
          state_nxt = DWELL;
          done_set  = 1'b1;
        end else if (&wdog) begin
          state_nxt = DWELL;
          tmo_set   = 1'b1;
        end
      end
      DWELL: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (dwell_last) begin
          if (next_pick[PW]) begin
            state_nxt = SELECT;
            sel_nxt   = next_pick[PW-1:0];
            wrap_inc  = (next_pick[PW-1:0] <= eng_sel);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_vec = done_set ? (NPORT'(1) << eng_sel) : '0;
  assign tmo_vec  = tmo_set  ? (NPORT'(1) << eng_sel) : '0;

  // Counters are held at zero outside their own state, so every entry starts a fresh count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      eng_sel    <= '0;
      fresh      <= '0;
      tmo_err    <= '0;
      sweep_cnt  <= '0;
      settle_cnt <= '0;
      wdog       <= '0;
      dwell_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      eng_sel    <= sel_nxt;
      fresh      <= (fresh & ~fresh_clr) | done_vec;
      tmo_err    <= (tmo_err & ~fresh_clr) | tmo_vec;
      if (wrap_inc) sweep_cnt <= sweep_cnt + 16'd1;
      settle_cnt <= (state == SELECT) ? settle_cnt + SW'(1) : '0;
      wdog       <= (state == RUN) ? wdog + TMO_W'(1) : '0;
      dwell_cnt  <= (state == DWELL) ? dwell_cnt + 16'd1 : '0;
    end
  end

  sfp_poll_ram #(
    .ADDR_W(PW + AW),
    .DW    (9)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .wr_addr(wr_addr),
    .wr_data(eng_result),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_sfp_poll_sched.sv
// tb/tb_sfp_poll_sched.sv - self-checking bench for sfp_poll_sched with a RAM readback scoreboard
module tb_sfp_poll_sched;

  localparam int NPORT = 4;
  localparam int PW    = 2;
  localparam int AW    = 4;
  localparam int TMO_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NPORT-1:0] port_mask;
  logic [15:0]      dwell;
  logic [PW-1:0]    eng_sel;
  logic             eng_run;
  logic             eng_strobe;
  logic [7:0]       eng_pc;
  logic [8:0]       eng_result;
  logic             eng_done;
  logic [PW+AW-1:0] rd_addr;
  logic [8:0]       rd_data;
  logic [NPORT-1:0] fresh;
  logic [NPORT-1:0] fresh_clr;
  logic [NPORT-1:0] tmo_err;
  logic [15:0]      sweep_cnt;
  logic             busy;

  always #5 clk = ~clk;

  sfp_poll_sched #(
    .NPORT (NPORT),
    .PW    (PW),
    .AW    (AW),
    .SETTLE(8),
    .TMO_W (TMO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .port_mask (port_mask),
    .dwell     (dwell),
    .eng_sel   (eng_sel),
    .eng_run   (eng_run),
    .eng_strobe(eng_strobe),
    .eng_pc    (eng_pc),
    .eng_result(eng_result),
    .eng_done  (eng_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .fresh     (fresh),
    .fresh_clr (fresh_clr),
    .tmo_err   (tmo_err),
    .sweep_cnt (sweep_cnt),
    .busy      (busy)
  );

  int         total = 0;
  int         bad   = 0;
  logic [8:0] mdl [64];
  logic [8:0] sb_q [$];
  int         addr_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_run(input int sel, input string tag);
    int n;
    n = 0;
    while (!eng_run && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_run"}, 32'(eng_run), 32'd1);
    chk({tag, "_sel"}, 32'(eng_sel), 32'(sel));
  endtask

  task automatic strobe(input int sel, input int pc, input int val, input bit done);
    eng_strobe = 1'b1;
    eng_pc     = 8'(pc);
    eng_result = 9'(val);
    eng_done   = done;
    if (pc < 16) mdl[sel*16 + pc] = 9'(val);
    tick();
    eng_strobe = 1'b0;
    eng_done   = 1'b0;
  endtask

  task automatic sweep(input int sel, input int base, input logic [NPORT-1:0] clr);
    for (int pc = 0; pc < 16; pc++) strobe(sel, pc, base + pc, 1'b0);
    eng_done  = 1'b1;
    fresh_clr = clr;
    tick();
    eng_done  = 1'b0;
    fresh_clr = '0;
    chk("dwell_run_low", 32'(eng_run), 32'd0);
  endtask

  task automatic read_all(input string tag);
    int         a;
    logic [8:0] e;
    for (int i = 0; i <= 64; i++) begin
      if (addr_q.size() > 0) begin
        a = addr_q.pop_front();
        e = sb_q.pop_front();
        chk($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(e));
      end
      if (i < 64) begin
        rd_addr = 6'(i);
        addr_q.push_back(i);
        sb_q.push_back(mdl[i]);
      end
      tick();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"},   32'(eng_sel),   32'd0);
    chk({tag, "_run"},   32'(eng_run),   32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_fresh"}, 32'(fresh),     32'd0);
    chk({tag, "_tmo"},   32'(tmo_err),   32'd0);
    chk({tag, "_sweep"}, 32'(sweep_cnt), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; port_mask = '0; dwell = '0;
    eng_strobe = 1'b0; eng_pc = '0; eng_result = '0; eng_done = 1'b0;
    rd_addr = '0; fresh_clr = '0;
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;

    // prefill every slot of every cage so later readbacks have known contents
    port_mask = 4'hf; enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      wait_run(c, $sformatf("pre%0d", c));
      sweep(c, 256 + c*16, '0);
    end
    enable = 1'b0;
    tick();
    chk("pre_busy",  32'(busy),      32'd0);
    chk("pre_fresh", 32'(fresh),     32'hf);
    chk("pre_sweep", 32'(sweep_cnt), 32'd0);
    fresh_clr = 4'hf; tick(); fresh_clr = '0;
    chk("pre_clr", 32'(fresh), 32'd0);

    // two-cage rotation, then abort mid-RUN after three strobes
    port_mask = 4'b0101; dwell = 16'd2; enable = 1'b1;
    wait_run(0, "p1a"); sweep(0, 100, '0);
    wait_run(2, "p1b"); sweep(2, 100, '0);
    chk("p1_sweep_pre", 32'(sweep_cnt), 32'd0);
    wait_run(0, "p1c");
    chk("p1_sweep", 32'(sweep_cnt), 32'd1);
    chk("p1_fresh", 32'(fresh), 32'b0101);
    for (int pc = 0; pc < 3; pc++) strobe(0, pc, 50 + pc, 1'b0);
    enable = 1'b0;
    tick();
    chk("abort_run",   32'(eng_run), 32'd0);
    chk("abort_busy",  32'(busy),    32'd0);
    chk("abort_fresh", 32'(fresh),   32'b0101);
    read_all("p1");

    // out-of-range pc discarded; strobe coincident with done still captured
    fresh_clr = 4'hf; tick(); fresh_clr = '0;
    port_mask = 4'b1000; dwell = '0; enable = 1'b1;
    wait_run(3, "p2");
    strobe(3, 20, 7, 1'b0);
    for (int pc = 0; pc < 15; pc++) strobe(3, pc, 400 + pc, 1'b0);
    strobe(3, 15, 99, 1'b1);
    chk("p2_run",   32'(eng_run), 32'd0);
    chk("p2_fresh", 32'(fresh),   32'b1000);
    enable = 1'b0;
    tick();
    read_all("p2");

    // watchdog on a silent engine, then reset mid-DWELL
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    port_mask = 4'b0010; dwell = 16'd3; enable = 1'b1;
    wait_run(1, "p3");
    n = 0;
    while (tmo_err == '0 && n < 400) begin
      if (eng_run) n++;
      tick();
    end
    chk("p3_tmo_window", 32'(n >= 250 && n <= 260), 32'd1);
    chk("p3_tmo",   32'(tmo_err), 32'b0010);
    chk("p3_fresh", 32'(fresh),   32'd0);
    chk("p3_run",   32'(eng_run), 32'd0);
    wait_run(1, "p3r");
    chk("p3_sweep",     32'(sweep_cnt), 32'd1);
    chk("p3_tmo_stick", 32'(tmo_err),   32'b0010);
    sweep(1, 150, '0);
    chk("p3_fresh2", 32'(fresh), 32'b0010);
    rst_n = 1'b0;
    tick();
    chk_reset("p3rst");
    rst_n = 1'b1; enable = 1'b0;
    tick();
    read_all("p3");

    // fresh_clr colliding with the done-set on the same bit
    port_mask = 4'b0001; dwell = '0; enable = 1'b1;
    wait_run(0, "p4");
    sweep(0, 180, 4'b0001);
    chk("p4_set_wins", 32'(fresh), 32'b0001);
    fresh_clr = 4'b0001; tick(); fresh_clr = '0;
    chk("p4_clr", 32'(fresh), 32'd0);
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
